// File: rtl/pipe_pkg.sv
// Shared helpers for the elastic buffering blocks (register chains, skid
// buffers, small FIFOs) that need to size an occupancy counter.
package pipe_pkg;

    // Bits needed to hold every count from 0 up to and including depth.
    // A depth below 1 is meaningless for a buffer; it still yields a legal
    // 1-bit width so that a bad parameter does not produce a zero-width port.
    function automatic int occ_w(input int depth);
        if (depth < 1) begin
            return 1;
        end
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One slot of the elastic register chain: a valid flag plus a data word.
// The slot accepts from its source whenever it is empty or the slot ahead
// of it is moving, so bubbles in front of a stalled word are squeezed out.
module pipe_stage #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    input  logic             rdy_in,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             rdy_out
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // The slot can take a new word if it is empty or its word is leaving.
    assign rdy_out = !r_valid || rdy_in;

    // Valid flag: cleared by reset and flush, otherwise follows the source
    // whenever the slot is allowed to advance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (rdy_out) begin
            r_valid <= src_valid;
        end
    end

    // Data word: only captured when a real word arrives, so a slot that
    // is stalled or receiving a bubble keeps its previous contents.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data <= '0;
        end else if (!flush && rdy_out && src_valid) begin
            r_data <= src_data;
        end
    end

    assign valid = r_valid;
    assign data  = r_data;

endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic register chain: DEPTH pipe_stage slots in series under a
// valid/ready handshake. Bubbles collapse so a free-flowing chain moves one
// word per cycle; flush empties every slot in one edge. The ready path is
// a purely combinational ripple from the output back to the input, which
// is acceptable for the short chains (DEPTH up to about 8) this is used for.
module pipe_reg_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [occ_w(DEPTH)-1:0]    occupancy
);

    localparam int OCC_W = occ_w(DEPTH);

    logic [DEPTH-1:0] w_valid_vec;
    logic [OCC_W-1:0] w_occ;

    // Stage 0 sits on the input side, stage DEPTH-1 drives the output.
    // Each stage keeps its own link signals so the ready ripple is a chain
    // of distinct nets rather than a self-referencing vector.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic             w_src_valid;
        logic [WIDTH-1:0] w_src_data;
        logic             w_rdy_in;
        logic             w_valid;
        logic [WIDTH-1:0] w_data;
        logic             w_rdy_out;

        if (gi == 0) begin : g_src_in
            assign w_src_valid = in_valid;
            assign w_src_data  = in_data;
        end else begin : g_src_prev
            assign w_src_valid = g_stage[gi-1].w_valid;
            assign w_src_data  = g_stage[gi-1].w_data;
        end

        if (gi == DEPTH - 1) begin : g_rdy_out
            assign w_rdy_in = out_ready;
        end else begin : g_rdy_next
            assign w_rdy_in = g_stage[gi+1].w_rdy_out;
        end

        pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk       (clk),
            .reset_n   (reset_n),
            .flush     (flush),
            .src_valid (w_src_valid),
            .src_data  (w_src_data),
            .rdy_in    (w_rdy_in),
            .valid     (w_valid),
            .data      (w_data),
            .rdy_out   (w_rdy_out)
        );

        assign w_valid_vec[gi] = w_valid;
    end

    // Flush blocks both handshakes in its cycle so nothing is transferred
    // while the slots are being cleared.
    assign in_ready  = g_stage[0].w_rdy_out && !flush;
    assign out_valid = g_stage[DEPTH-1].w_valid && !flush;
    assign out_data  = g_stage[DEPTH-1].w_data;

    // Occupancy is the number of occupied slots, taken from register state.
    always_comb begin
        w_occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ = w_occ + OCC_W'(w_valid_vec[i]);
        end
    end

    assign occupancy = w_occ;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain: three instances (DEPTH 1, 2, 3; WIDTH 4) share
// one stimulus. A queue-style model holds the words in flight with their
// slot positions and derives the expected handshake, data and occupancy.
module tb_pipe_reg_chain;

    localparam int NU = 3;   // unit u has DEPTH u+1

    logic       clk;
    logic       reset_n;
    logic       flush;
    logic       in_valid;
    logic       out_ready;
    logic [3:0] in_data;

    logic [2:0] ov;
    logic [2:0] ir;
    logic [3:0] od [NU];
    logic [0:0] occ_d1;
    logic [1:0] occ_d2;
    logic [1:0] occ_d3;

    int checks;
    int errors;

    // Model: per unit, words in arrival order with their slot index.
    int         m_cnt [NU];
    int         m_pos [NU][3];
    logic [3:0] m_dat [NU][3];

    pipe_reg_chain #(.WIDTH(4), .DEPTH(1)) u_d1 (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
        .occupancy(occ_d1)
    );

    pipe_reg_chain #(.WIDTH(4), .DEPTH(2)) u_d2 (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
        .occupancy(occ_d2)
    );

    pipe_reg_chain #(.WIDTH(4), .DEPTH(3)) u_d3 (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
        .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
        .occupancy(occ_d3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    function automatic int occ_of(input int u);
        case (u)
            0:       return int'(occ_d1);
            1:       return int'(occ_d2);
            default: return int'(occ_d3);
        endcase
    endfunction

    function automatic bit m_ov(input int u);
        return !flush && (m_cnt[u] > 0) && (m_pos[u][0] == u);
    endfunction

    function automatic bit m_ir(input int u);
        return !flush && ((m_cnt[u] < u + 1) || out_ready);
    endfunction

    // Advance the model across one rising edge using the pre-edge inputs.
    task automatic model_edge(input int u);
        int dep;
        int n;
        int lim;
        bit emit;
        bit acc;
        dep = u + 1;
        n   = m_cnt[u];
        if (!reset_n || flush) begin
            m_cnt[u] = 0;
            return;
        end
        emit = (n > 0) && (m_pos[u][0] == dep - 1) && out_ready;
        acc  = in_valid && ((n < dep) || out_ready);
        if (emit) begin
            for (int k = 0; k < n - 1; k++) begin
                m_pos[u][k] = m_pos[u][k+1];
                m_dat[u][k] = m_dat[u][k+1];
            end
            n--;
        end
        for (int k = 0; k < n; k++) begin
            lim = (k == 0) ? dep - 1 : m_pos[u][k-1] - 1;
            if (m_pos[u][k] < lim) m_pos[u][k]++;
        end
        if (acc) begin
            m_pos[u][n] = 0;
            m_dat[u][n] = in_data;
            n++;
        end
        m_cnt[u] = n;
    endtask

    task automatic tick();
        @(posedge clk);
        for (int u = 0; u < NU; u++) model_edge(u);
        #1;
    endtask

    task automatic drain();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 4'h0;
        for (int u = 0; u < NU; u++) m_cnt[u] = 0;
        #2;
        for (int u = 0; u < NU; u++) begin
            checks++; if (ov[u] !== 1'b0) begin errors++; $display("FAIL rst_ov d%0d: got %b want 0", u+1, ov[u]); end
            checks++; if (od[u] !== 4'h0) begin errors++; $display("FAIL rst_od d%0d: got %h want 0", u+1, od[u]); end
            checks++; if (occ_of(u) !== 0) begin errors++; $display("FAIL rst_occ d%0d: got %0d want 0", u+1, occ_of(u)); end
            checks++; if (ir[u] !== 1'b1) begin errors++; $display("FAIL rst_ir d%0d: got %b want 1", u+1, ir[u]); end
        end
        tick();
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_streaming();
        drain();
        for (int c = 0; c < 7; c++) begin
            in_valid = (c < 4);
            in_data  = 4'(c + 1);
            #1;
            checks++; if (ov[1] !== ((c >= 2) && (c <= 5))) begin errors++; $display("FAIL stream_ov cyc %0d: got %b want %b", c, ov[1], ((c >= 2) && (c <= 5))); end
            if (c >= 2 && c <= 5) begin
                checks++; if (od[1] !== 4'(c - 1)) begin errors++; $display("FAIL stream_od cyc %0d: got %h want %h", c, od[1], 4'(c - 1)); end
            end
            checks++; if (ir[1] !== 1'b1) begin errors++; $display("FAIL stream_ir cyc %0d: got %b want 1", c, ir[1]); end
            tick();
        end
    endtask

    task automatic test_back_pressure();
        drain();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 4'hA; tick();
        in_data = 4'hB; tick();
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (ir[1] !== 1'b0) begin errors++; $display("FAIL bp_ir cyc %0d: got %b want 0", c, ir[1]); end
            checks++; if (occ_of(1) !== 2) begin errors++; $display("FAIL bp_occ cyc %0d: got %0d want 2", c, occ_of(1)); end
            checks++; if (od[1] !== 4'hA) begin errors++; $display("FAIL bp_od cyc %0d: got %h want a", c, od[1]); end
            checks++; if (ov[1] !== 1'b1) begin errors++; $display("FAIL bp_ov cyc %0d: got %b want 1", c, ov[1]); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (ov[1] !== 1'b1 || od[1] !== 4'hA) begin errors++; $display("FAIL bp_rel0: got v%b %h want v1 a", ov[1], od[1]); end
        tick();
        checks++; if (ov[1] !== 1'b1 || od[1] !== 4'hB) begin errors++; $display("FAIL bp_rel1: got v%b %h want v1 b", ov[1], od[1]); end
        tick();
        checks++; if (ov[1] !== 1'b0 || occ_of(1) !== 0) begin errors++; $display("FAIL bp_empty: got v%b occ %0d want v0 occ 0", ov[1], occ_of(1)); end
    endtask

    task automatic test_bubble();
        drain();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 4'h5; tick();
        in_valid = 1'b0;
        #1;
        checks++; if (ov[2] !== 1'b0) begin errors++; $display("FAIL bub_ov_e1: got %b want 0", ov[2]); end
        tick();
        checks++; if (ov[2] !== 1'b0) begin errors++; $display("FAIL bub_ov_e2: got %b want 0", ov[2]); end
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++; if (ov[2] !== 1'b1 || od[2] !== 4'h5) begin errors++; $display("FAIL bub_last %0d: got v%b %h want v1 5", c, ov[2], od[2]); end
            checks++; if (occ_of(2) !== 1) begin errors++; $display("FAIL bub_occ %0d: got %0d want 1", c, occ_of(2)); end
            checks++; if (ir[2] !== 1'b1) begin errors++; $display("FAIL bub_ir %0d: got %b want 1", c, ir[2]); end
        end
    endtask

    task automatic test_flush();
        drain();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 4'h1; tick();
        in_data = 4'h2; tick();
        flush = 1'b1; in_data = 4'hC;
        #1;
        checks++; if (ir[1] !== 1'b0) begin errors++; $display("FAIL fl_ir: got %b want 0", ir[1]); end
        checks++; if (ov[1] !== 1'b0) begin errors++; $display("FAIL fl_ov: got %b want 0", ov[1]); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (occ_of(1) !== 0) begin errors++; $display("FAIL fl_occ: got %0d want 0", occ_of(1)); end
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (ov[1] !== 1'b0) begin errors++; $display("FAIL fl_after %0d: got %b want 0", c, ov[1]); end
            tick();
        end
    endtask

    task automatic test_full_simul();
        drain();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 4'h3; tick();
        in_data = 4'h7; out_ready = 1'b1;
        #1;
        checks++; if (ov[0] !== 1'b1 || od[0] !== 4'h3) begin errors++; $display("FAIL full_old: got v%b %h want v1 3", ov[0], od[0]); end
        checks++; if (ir[0] !== 1'b1) begin errors++; $display("FAIL full_ir: got %b want 1", ir[0]); end
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        checks++; if (ov[0] !== 1'b1 || od[0] !== 4'h7) begin errors++; $display("FAIL full_new: got v%b %h want v1 7", ov[0], od[0]); end
        checks++; if (occ_of(0) !== 1) begin errors++; $display("FAIL full_occ: got %0d want 1", occ_of(0)); end
    endtask

    task automatic test_reset_mid();
        drain();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 4'h9; tick();
        in_data = 4'h6; tick();
        in_valid = 1'b0;
        #1;
        checks++; if (occ_of(1) !== 2) begin errors++; $display("FAIL rm_pre_occ: got %0d want 2", occ_of(1)); end
        reset_n = 1'b0;
        for (int u = 0; u < NU; u++) m_cnt[u] = 0;
        #1;
        checks++; if (ov[1] !== 1'b0) begin errors++; $display("FAIL rm_ov: got %b want 0", ov[1]); end
        checks++; if (od[1] !== 4'h0) begin errors++; $display("FAIL rm_od: got %h want 0", od[1]); end
        checks++; if (occ_of(1) !== 0) begin errors++; $display("FAIL rm_occ: got %0d want 0", occ_of(1)); end
        checks++; if (ir[1] !== 1'b1) begin errors++; $display("FAIL rm_ir: got %b want 1", ir[1]); end
        tick();
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_data   = 4'($urandom);
            #1;
            for (int u = 0; u < NU; u++) begin
                checks++; if (ov[u] !== m_ov(u)) begin errors++; $display("FAIL rnd_ov d%0d cyc %0d: got %b want %b", u+1, c, ov[u], m_ov(u)); end
                checks++; if (ir[u] !== m_ir(u)) begin errors++; $display("FAIL rnd_ir d%0d cyc %0d: got %b want %b", u+1, c, ir[u], m_ir(u)); end
                checks++; if (occ_of(u) !== m_cnt[u]) begin errors++; $display("FAIL rnd_occ d%0d cyc %0d: got %0d want %0d", u+1, c, occ_of(u), m_cnt[u]); end
                if (m_ov(u)) begin
                    checks++; if (od[u] !== m_dat[u][0]) begin errors++; $display("FAIL rnd_od d%0d cyc %0d: got %h want %h", u+1, c, od[u], m_dat[u][0]); end
                end
            end
            tick();
        end
        flush = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_streaming();
        test_back_pressure();
        test_bubble();
        test_flush();
        test_full_simul();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
